// File: rtl/sum_latch_pkg.sv
// Shared types and sizing helpers for the sum-latch UART datapath.
// Result width grows with the operand count; bytes are sent LSB first.
package sum_latch_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    function automatic int res_width(input int data_w, input int num_ops);
        return data_w + $clog2(num_ops);
    endfunction

    function automatic int num_bytes(input int res_w);
        return (res_w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for one byte; a start on the done cycle chains the
// next frame with no idle gap.
module uart_tx_byte
    import sum_latch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       txd,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t      state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     sh;
    logic           tick;

    assign tick = (cnt == LAST);
    assign done = (state == STOP) && tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            txd     <= 1'b1;
        end else if (start) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= byte_in;
            txd     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    txd <= 1'b1;
                end
                START: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= DATA;
                        txd   <= sh[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            // shift keeps the bit after the current one in sh[1]
                            bit_idx <= bit_idx + 3'd1;
                            sh      <= sh >> 1;
                            txd     <= sh[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches NUM_OPS operands, combines enabled channels as sum or difference,
// and on a tx_en rising edge sends the result LSB byte first as 8N1 frames.
module sum_latch_uart_tx
    import sum_latch_pkg::*;
#(
    parameter  int DATA_W       = 4,
    parameter  int NUM_OPS      = 2,
    parameter  int CLKS_PER_BIT = 868,
    localparam int RES_W        = res_width(DATA_W, NUM_OPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [NUM_OPS-1:0] save_n,
    input  logic [NUM_OPS-1:0] chan_en,
    input  logic               mode,
    input  logic               tx_en,
    output logic [RES_W-1:0]   result,
    output logic               uart_txd,
    output logic               uart_busy
);

    localparam int NBYTES = num_bytes(RES_W);
    localparam int SNAP_W = NBYTES * 8 + 8;
    localparam int BW     = $clog2(NBYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    logic [DATA_W-1:0] ops [NUM_OPS];
    logic              tx_en_q;
    logic [SNAP_W-1:0] snap;
    logic [SNAP_W-1:0] pad;
    logic [BW-1:0]     byte_idx;
    logic [7:0]        byte_in;
    logic              done;
    logic              last_done;
    logic              accept;
    logic              next_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++)
                if (!save_n[i]) ops[i] <= data_in;
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (chan_en[i]) begin
                if (mode && i != 0) result = result - RES_W'(ops[i]);
                else                result = result + RES_W'(ops[i]);
            end
        end
    end

    // A start may land on the very edge the last stop bit ends.
    assign pad       = SNAP_W'(result);
    assign last_done = done && (byte_idx == LAST_BYTE);
    assign accept    = tx_en && !tx_en_q && (!uart_busy || last_done);
    assign next_byte = done && (byte_idx != LAST_BYTE);
    assign byte_in   = accept ? pad[7:0] : snap[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_en_q   <= 1'b0;
            snap      <= '0;
            byte_idx  <= '0;
            uart_busy <= 1'b0;
        end else begin
            tx_en_q <= tx_en;
            if (accept) begin
                snap      <= pad;
                byte_idx  <= '0;
                uart_busy <= 1'b1;
            end else if (next_byte) begin
                snap     <= snap >> 8;
                byte_idx <= byte_idx + BW'(1);
            end else if (last_done) begin
                uart_busy <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .start   (accept || next_byte),
        .byte_in (byte_in),
        .txd     (uart_txd),
        .done    (done)
    );

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Bench for sum_latch_uart_tx: a 1-byte and a 2-byte instance checked
// against an arithmetic model and an ideal 8N1 frame builder.
module tb_sum_latch_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;

    logic [3:0] din_a;
    logic [1:0] save_a;
    logic [1:0] en_a;
    logic       mode_a;
    logic       tx_a;
    logic [4:0] res_a;
    logic       txd_a;
    logic       busy_a;

    logic [7:0] din_b;
    logic [3:0] save_b;
    logic [3:0] en_b;
    logic       mode_b;
    logic       tx_b;
    logic [9:0] res_b;
    logic       txd_b;
    logic       busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ma [2];
    int mb [4];

    sum_latch_uart_tx #(
        .DATA_W(4), .NUM_OPS(2), .CLKS_PER_BIT(CPB)
    ) u_a (
        .clk(clk), .reset(reset), .data_in(din_a), .save_n(save_a),
        .chan_en(en_a), .mode(mode_a), .tx_en(tx_a), .result(res_a),
        .uart_txd(txd_a), .uart_busy(busy_a)
    );

    sum_latch_uart_tx #(
        .DATA_W(8), .NUM_OPS(4), .CLKS_PER_BIT(CPB)
    ) u_b (
        .clk(clk), .reset(reset), .data_in(din_b), .save_n(save_b),
        .chan_en(en_b), .mode(mode_b), .tx_en(tx_b), .result(res_b),
        .uart_txd(txd_b), .uart_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int model(input int sel, input int m, input int en);
        int n  = sel ? 4 : 2;
        int rw = sel ? 10 : 5;
        int acc = 0;
        for (int i = 0; i < n; i++) begin
            int v = sel ? mb[i] : ma[i];
            if ((en >> i) & 1) acc = (m != 0 && i > 0) ? acc - v : acc + v;
        end
        return acc & ((1 << rw) - 1);
    endfunction

    task automatic set_tx(input int sel, input logic v);
        if (sel != 0) tx_b = v;
        else          tx_a = v;
    endtask

    task automatic load(input int sel, input int mask, input int val);
        @(negedge clk);
        if (sel != 0) begin
            din_b  = 8'(val);
            save_b = ~4'(mask);
        end else begin
            din_a  = 4'(val);
            save_a = ~2'(mask);
        end
        @(negedge clk);
        save_a = '1;
        save_b = '1;
        for (int i = 0; i < 4; i++)
            if ((mask >> i) & 1) begin
                if (sel != 0) mb[i] = val;
                else if (i < 2) ma[i] = val;
            end
    endtask

    // act: 0 plain, 1 collision edge plus reload of op0, 2 hold tx_en high
    task automatic send(input int sel, input int act, input int val);
        int   nb    = sel ? 2 : 1;
        int   total = nb * 10 * CPB;
        int   busy_n = 0;
        int   bad   = 0;
        logic q[$];
        logic t;
        logic b;
        @(negedge clk);
        set_tx(sel, 1'b1);
        for (int cyc = 0; cyc < total + 10; cyc++) begin
            @(negedge clk);
            t = sel ? txd_b : txd_a;
            b = sel ? busy_b : busy_a;
            if (cyc == 0) check("busy_rise", 32'(b), 1);
            if (b) begin
                busy_n++;
                q.push_back(t);
            end else if (busy_n > 0) begin
                break;
            end
            if (cyc == 0 && act != 2) set_tx(sel, 1'b0);
            if (act == 1) begin
                if (cyc == 8)  set_tx(sel, 1'b1);
                if (cyc == 9)  set_tx(sel, 1'b0);
                if (cyc == 12) begin din_a = 4'd1; save_a = 2'b10; end
                if (cyc == 13) begin save_a = 2'b11; ma[0] = 1; end
            end
        end
        check("busy_len", 32'(busy_n), 32'(total));
        for (int bi = 0; bi < nb; bi++) begin
            int ob = 0;
            int eb = (val >> (bi * 8)) & 255;
            for (int k = 0; k < 10; k++) begin
                int e = (k == 0) ? 0 : (k == 9) ? 1 : (eb >> (k - 1)) & 1;
                for (int s = 0; s < CPB; s++) begin
                    int idx = bi * 10 * CPB + k * CPB + s;
                    if (idx >= q.size() || int'(q[idx]) != e) bad++;
                end
                if (k >= 1 && k <= 8) begin
                    int mid = bi * 10 * CPB + k * CPB + 1;
                    if (mid < q.size() && q[mid]) ob |= 1 << (k - 1);
                end
            end
            check("frame_byte", 32'(ob), 32'(eb));
        end
        check("bit_shape", 32'(bad), 0);
    endtask

    task automatic count_busy(input int sel, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel ? busy_b : busy_a) hi++;
        end
    endtask

    initial begin
        int hi;
        int exp;
        reset = 1'b1;
        din_a = '0; save_a = '1; en_a = 2'b11; mode_a = 0; tx_a = 0;
        din_b = '0; save_b = '1; en_b = 4'hF; mode_b = 0; tx_b = 0;
        for (int i = 0; i < 2; i++) ma[i] = 0;
        for (int i = 0; i < 4; i++) mb[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd_a), 1);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_res", 32'(res_b), 0);
        reset = 1'b0;

        load(0, 1, 9);
        load(0, 2, 7);
        check("sum_res", 32'(res_a), 32'(model(0, 0, 3)));
        send(0, 0, model(0, 0, 3));

        // reset in the middle of the data bits
        @(negedge clk);
        tx_a = 1'b1;
        @(negedge clk);
        tx_a = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 32'(busy_a), 1);
        reset = 1'b1;
        #1;
        check("async_txd", 32'(txd_a), 1);
        check("async_busy", 32'(busy_a), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) ma[i] = 0;
        for (int i = 0; i < 4; i++) mb[i] = 0;
        count_busy(0, 60, hi);
        check("no_resume", 32'(hi), 0);

        load(0, 1, 3);
        load(0, 2, 5);
        mode_a = 1;
        #1;
        check("diff_res", 32'(res_a), 32'(model(0, 1, 3)));
        send(0, 0, model(0, 1, 3));
        en_a = 2'b01;
        #1;
        check("mask01", 32'(res_a), 32'(model(0, 1, 1)));
        en_a = 2'b00;
        #1;
        check("mask00", 32'(res_a), 32'(model(0, 1, 0)));
        en_a = 2'b11;
        mode_a = 0;

        load(1, 15, 255);
        check("multi_res", 32'(res_b), 32'(model(1, 0, 15)));
        send(1, 0, model(1, 0, 15));

        load(0, 1, 9);
        load(0, 2, 7);
        exp = model(0, 0, 3);
        send(0, 1, exp);
        check("reload_res", 32'(res_a), 32'(model(0, 0, 3)));
        send(0, 0, model(0, 0, 3));

        send(0, 2, model(0, 0, 3));
        count_busy(0, 200, hi);
        check("hold_once", 32'(hi), 0);
        tx_a = 1'b0;

        load(0, 3, 6);
        check("both6", 32'(res_a), 32'(model(0, 0, 3)));

        for (int it = 0; it < 16; it++) begin
            load(0, $urandom_range(1, 3), $urandom_range(0, 15));
            en_a   = 2'($urandom_range(0, 3));
            mode_a = 1'($urandom_range(0, 1));
            #1;
            check("rnd_a", 32'(res_a), 32'(model(0, mode_a, en_a)));
            send(0, 0, model(0, mode_a, en_a));
        end
        for (int it = 0; it < 6; it++) begin
            load(1, $urandom_range(1, 15), $urandom_range(0, 255));
            en_b   = 4'($urandom_range(0, 15));
            mode_b = 1'($urandom_range(0, 1));
            #1;
            check("rnd_b", 32'(res_b), 32'(model(1, mode_b, en_b)));
            send(1, 0, model(1, mode_b, en_b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
